avalon_ram_responder: RTL and testbench

- Avalon-MM slave that answers the core data-bus master port. It consumes read/write/byteenable/address and returns waitrequest, readdata, readdatavalid, writeresponsevalid and response.
- Backed by a word-organised on-chip RAM, with a programmable number of wait states and a fixed response latency.
- Serves as the default data memory and as the bench target for the core's data interface (bus_data_* signals).

---
 rtl/avalon_ram_responder.sv | 135 +++++++++++++
 tb/tb_avalon_ram_responder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_ram_responder.sv
// Avalon-MM slave backed by a word-organised on-chip RAM, with programmable
// wait states and a fixed-latency, never-stalling response pipeline.
module avalon_ram_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0,
    parameter int LATENCY     = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] avalon_s_address,
    input  logic        avalon_s_read,
    input  logic        avalon_s_write,
    input  logic [3:0]  avalon_s_byteenable,
    input  logic [31:0] avalon_s_writedata,
    output logic        avalon_s_waitrequest,
    output logic [31:0] avalon_s_readdata,
    output logic        avalon_s_readdatavalid,
    output logic        avalon_s_writeresponsevalid,
    output logic [1:0]  avalon_s_response
);
    localparam int         IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS          = 4'(WAIT_STATES);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic [31:0]        mem [DEPTH_WORDS];
    logic [3:0]         wcnt_q, wcnt_d;
    logic [LATENCY-1:0] rv_q, rv_d;
    logic [LATENCY-1:0] wv_q, wv_d;
    logic [1:0]         resp_q [LATENCY];
    logic [1:0]         resp_d [LATENCY];
    logic [31:0]        data_q [LATENCY];
    logic [31:0]        data_d [LATENCY];

    logic               cmd;
    logic               accept;
    logic               oor;
    logic               mem_we;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        mem_rword;
    logic [31:0]        mem_wword;
    logic [1:0]         addr_lsb_unused;

    assign addr_lsb_unused = avalon_s_address[1:0];

    // Command decode, stall generation and byte-lane merge for writes
    always_comb begin
        cmd                  = avalon_s_read | avalon_s_write;
        idx                  = avalon_s_address[IDX_W+1:2];
        oor                  = |avalon_s_address[31:IDX_W+2];
        avalon_s_waitrequest = rst_i | (cmd & (wcnt_q != WS));
        accept               = cmd & ~avalon_s_waitrequest;
        mem_rword            = mem[idx];
        mem_we               = accept & avalon_s_write & ~avalon_s_read & ~oor;
        mem_wword            = mem_rword;
        for (int b = 0; b < 4; b++) begin
            if (avalon_s_byteenable[b]) begin
                mem_wword[8*b +: 8] = avalon_s_writedata[8*b +: 8];
            end else begin
                mem_wword[8*b +: 8] = mem_rword[8*b +: 8];
            end
        end
    end

    // Wait counter restarts after acceptance or when the command goes away
    always_comb begin
        if (cmd && (wcnt_q < WS)) begin
            wcnt_d = wcnt_q + 4'd1;
        end else begin
            wcnt_d = 4'd0;
        end
    end

    // Stage 0 captures the accepted command; later stages just shift
    always_comb begin
        rv_d[0] = accept & avalon_s_read;
        wv_d[0] = accept & avalon_s_write & ~avalon_s_read;
        if (!accept) begin
            resp_d[0] = RESP_OKAY;
            data_d[0] = 32'd0;
        end else if (avalon_s_read && avalon_s_write) begin
            resp_d[0] = RESP_DECERR;
            data_d[0] = 32'd0;
        end else if (oor) begin
            resp_d[0] = RESP_SLVERR;
            data_d[0] = 32'd0;
        end else if (avalon_s_read) begin
            resp_d[0] = RESP_OKAY;
            data_d[0] = mem_rword;
        end else begin
            resp_d[0] = RESP_OKAY;
            data_d[0] = 32'd0;
        end
        for (int k = 1; k < LATENCY; k++) begin
            rv_d[k]   = rv_q[k-1];
            wv_d[k]   = wv_q[k-1];
            resp_d[k] = resp_q[k-1];
            data_d[k] = data_q[k-1];
        end
    end

    // Control and pipeline state; reset flushes everything in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wcnt_q <= 4'd0;
            rv_q   <= {LATENCY{1'b0}};
            wv_q   <= {LATENCY{1'b0}};
            for (int k = 0; k < LATENCY; k++) begin
                resp_q[k] <= 2'b00;
                data_q[k] <= 32'd0;
            end
        end else begin
            wcnt_q <= wcnt_d;
            rv_q   <= rv_d;
            wv_q   <= wv_d;
            for (int k = 0; k < LATENCY; k++) begin
                resp_q[k] <= resp_d[k];
                data_q[k] <= data_d[k];
            end
        end
    end

    // RAM array is deliberately outside reset so contents survive it
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[idx] <= mem_wword;
        end
    end

    assign avalon_s_readdatavalid      = rv_q[LATENCY-1];
    assign avalon_s_writeresponsevalid = wv_q[LATENCY-1];
    assign avalon_s_response           = resp_q[LATENCY-1];
    assign avalon_s_readdata           = data_q[LATENCY-1];
endmodule

// File: tb/tb_avalon_ram_responder.sv
// Bench for avalon_ram_responder: three instances with different timing,
// checked cycle by cycle against a queue-based model of expected responses.
module tb_avalon_ram_responder;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst   [NI];
    logic [31:0] addr  [NI];
    logic        rd    [NI];
    logic        wr    [NI];
    logic [3:0]  be    [NI];
    logic [31:0] wd    [NI];
    logic        wreq  [NI];
    logic [31:0] rdata [NI];
    logic        rdv   [NI];
    logic        wrv   [NI];
    logic [1:0]  resp  [NI];

    avalon_ram_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .LATENCY(1)) dut0 (
        .clk_i(clk), .rst_i(rst[0]), .avalon_s_address(addr[0]), .avalon_s_read(rd[0]),
        .avalon_s_write(wr[0]), .avalon_s_byteenable(be[0]), .avalon_s_writedata(wd[0]),
        .avalon_s_waitrequest(wreq[0]), .avalon_s_readdata(rdata[0]),
        .avalon_s_readdatavalid(rdv[0]), .avalon_s_writeresponsevalid(wrv[0]),
        .avalon_s_response(resp[0]));

    avalon_ram_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3), .LATENCY(2)) dut1 (
        .clk_i(clk), .rst_i(rst[1]), .avalon_s_address(addr[1]), .avalon_s_read(rd[1]),
        .avalon_s_write(wr[1]), .avalon_s_byteenable(be[1]), .avalon_s_writedata(wd[1]),
        .avalon_s_waitrequest(wreq[1]), .avalon_s_readdata(rdata[1]),
        .avalon_s_readdatavalid(rdv[1]), .avalon_s_writeresponsevalid(wrv[1]),
        .avalon_s_response(resp[1]));

    avalon_ram_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .LATENCY(3)) dut2 (
        .clk_i(clk), .rst_i(rst[2]), .avalon_s_address(addr[2]), .avalon_s_read(rd[2]),
        .avalon_s_write(wr[2]), .avalon_s_byteenable(be[2]), .avalon_s_writedata(wd[2]),
        .avalon_s_waitrequest(wreq[2]), .avalon_s_readdata(rdata[2]),
        .avalon_s_readdatavalid(rdv[2]), .avalon_s_writeresponsevalid(wrv[2]),
        .avalon_s_response(resp[2]));

    typedef struct {
        int         due;
        logic       rv;
        logic       wv;
        logic [1:0] resp;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [3:0]  b;
        logic [31:0] d;
        logic        erv;
        logic        ewv;
        logic [1:0]  eresp;
        logic [31:0] edata;
    } vec_t;

    exp_t        expq    [NI][$];
    logic [31:0] ref_mem [NI][1024];
    int          acc_cyc [NI];
    int          total = 0;
    int          bad   = 0;

    function automatic int ws_of(input int i);
        case (i)
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int lat_of(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, req);
        end
    endtask

    // Reference: what an accepted command must produce, LATENCY cycles later
    function automatic void model_accept(input int i, input logic r, input logic w,
                                         input logic [31:0] a, input logic [3:0] b,
                                         input logic [31:0] d);
        exp_t e;
        int   word;
        e.due  = cyc + lat_of(i);
        e.rv   = r;
        e.wv   = w & ~r;
        e.resp = 2'b00;
        e.data = 32'd0;
        word   = int'(a >> 2);
        if (r && w) begin
            e.resp = 2'b11;
        end else if (a >= 32'd4096) begin
            e.resp = 2'b10;
        end else if (r) begin
            e.data = ref_mem[i][word];
        end else begin
            for (int k = 0; k < 4; k++)
                if (b[k]) ref_mem[i][word][8*k +: 8] = d[8*k +: 8];
        end
        expq[i].push_back(e);
    endfunction

    // Every cycle, each instance shows either the entry due now or idle zeros
    exp_t ce;
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            ce = '{due: cyc, rv: 1'b0, wv: 1'b0, resp: 2'b00, data: 32'd0};
            while (expq[i].size() > 0 && expq[i][0].due < cyc) begin
                chk($sformatf("missed_entry_i%0d", i), 64'(cyc), 64'(expq[i][0].due));
                void'(expq[i].pop_front());
            end
            if (expq[i].size() > 0 && expq[i][0].due == cyc) ce = expq[i].pop_front();
            chk($sformatf("resp_i%0d", i),
                {28'd0, rdv[i], wrv[i], resp[i], rdata[i]},
                {28'd0, ce.rv, ce.wv, ce.resp, ce.data});
        end
    end

    // Present a command (called just after a rising edge) and hold it until accepted
    task automatic do_cmd(input int i, input logic r, input logic w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d);
        rd[i] = r; wr[i] = w; addr[i] = a; be[i] = b; wd[i] = d;
        for (int k = 0; k <= ws_of(i); k++) begin
            @(negedge clk);
            chk($sformatf("waitreq_i%0d_k%0d", i, k), 64'(wreq[i]), 64'(k < ws_of(i)));
            if (k == ws_of(i)) begin
                model_accept(i, r, w, a, b, d);
                acc_cyc[i] = cyc;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int i);
        rd[i] = 1'b0;
        wr[i] = 1'b0;
    endtask

    task automatic pulse_reset(input int i);
        rst[i] = 1'b1;
        @(negedge clk);
        chk($sformatf("waitreq_in_reset_i%0d", i), 64'(wreq[i]), 64'd1);
        @(posedge clk); #1;
        rst[i] = 1'b0;
        expq[i].delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    vec_t        tbl [15];
    int          kind;
    int          a1;
    logic [31:0] ra;
    logic        rr;

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0;
            addr[i] = 32'd0; be[i] = 4'd0; wd[i] = 32'd0;
        end
        tbl[0]  = '{1'b0, 1'b1, 32'h10,       4'hF, 32'hDEADBEEF, 1'b0, 1'b1, 2'b00, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h10,       4'hF, 32'h0,        1'b1, 1'b0, 2'b00, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 1'b1, 32'h20,       4'hF, 32'h11223344, 1'b0, 1'b1, 2'b00, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 32'h20,       4'h5, 32'hAABBCCDD, 1'b0, 1'b1, 2'b00, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 32'h20,       4'h0, 32'h0,        1'b1, 1'b0, 2'b00, 32'h11BB33DD};
        tbl[5]  = '{1'b1, 1'b0, 32'h1000,     4'hF, 32'h0,        1'b1, 1'b0, 2'b10, 32'h0};
        tbl[6]  = '{1'b0, 1'b1, 32'h1000,     4'hF, 32'h0BADF00D, 1'b0, 1'b1, 2'b10, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,        4'hF, 32'h0,        1'b1, 1'b0, 2'b00, 32'hA5000000};
        tbl[8]  = '{1'b1, 1'b1, 32'h4,        4'hF, 32'h12345678, 1'b1, 1'b0, 2'b11, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 32'h4,        4'hF, 32'h0,        1'b1, 1'b0, 2'b00, 32'hA5000001};
        tbl[10] = '{1'b0, 1'b1, 32'h8,        4'h0, 32'hFFFFFFFF, 1'b0, 1'b1, 2'b00, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 32'h8,        4'hF, 32'h0,        1'b1, 1'b0, 2'b00, 32'hA5000002};
        tbl[12] = '{1'b0, 1'b1, 32'hFFC,      4'hF, 32'hCAFEF00D, 1'b0, 1'b1, 2'b00, 32'h0};
        tbl[13] = '{1'b1, 1'b0, 32'hFFF,      4'h0, 32'h0,        1'b1, 1'b0, 2'b00, 32'hCAFEF00D};
        tbl[14] = '{1'b1, 1'b0, 32'hFFFFFFFC, 4'hF, 32'h0,        1'b1, 1'b0, 2'b10, 32'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++)
            chk($sformatf("reset_state_i%0d", i),
                {27'd0, wreq[i], rdv[i], wrv[i], resp[i], rdata[i]}, {27'd0, 1'b1, 36'd0});
        @(posedge clk); #1;
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++)
            chk($sformatf("idle_waitreq_i%0d", i), 64'(wreq[i]), 64'd0);
        @(posedge clk); #1;

        // Known contents for words 0..15 of every instance
        for (int i = 0; i < NI; i++) begin
            for (int w = 0; w < 16; w++)
                do_cmd(i, 1'b0, 1'b1, 32'(w * 4), 4'hF, 32'hA5000000 | 32'(w));
            idle(i);
        end
        repeat (4) @(posedge clk);
        #1;

        // Directed vectors on the default-timing instance
        for (int k = 0; k < 15; k++) begin
            do_cmd(0, tbl[k].r, tbl[k].w, tbl[k].a, tbl[k].b, tbl[k].d);
            idle(0);
            @(negedge clk);
            chk($sformatf("tbl%0d", k),
                {28'd0, rdv[0], wrv[0], resp[0], rdata[0]},
                {28'd0, tbl[k].erv, tbl[k].ewv, tbl[k].eresp, tbl[k].edata});
            @(posedge clk); #1;
        end

        // Read directly after write on consecutive cycles
        do_cmd(0, 1'b0, 1'b1, 32'h30, 4'hF, 32'h600DCAFE);
        do_cmd(0, 1'b1, 1'b0, 32'h30, 4'hF, 32'h0);
        idle(0);
        repeat (3) @(posedge clk);
        #1;

        // Wait states: single held read, then back-to-back commands
        do_cmd(1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        idle(1);
        repeat (4) @(posedge clk);
        #1;
        do_cmd(1, 1'b1, 1'b0, 32'h14, 4'hF, 32'h0);
        a1 = acc_cyc[1];
        do_cmd(1, 1'b0, 1'b1, 32'h18, 4'h3, 32'h0000BEEF);
        chk("b2b_spacing_1", 64'(acc_cyc[1] - a1), 64'd4);
        a1 = acc_cyc[1];
        do_cmd(1, 1'b1, 1'b0, 32'h18, 4'hF, 32'h0);
        chk("b2b_spacing_2", 64'(acc_cyc[1] - a1), 64'd4);
        idle(1);
        repeat (4) @(posedge clk);
        #1;

        // Ordering with LATENCY=3, then a reset with two entries still in flight
        do_cmd(2, 1'b0, 1'b1, 32'h20, 4'hF, 32'h11110000);
        do_cmd(2, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        do_cmd(2, 1'b0, 1'b1, 32'h24, 4'hF, 32'h22220000);
        do_cmd(2, 1'b1, 1'b0, 32'h24, 4'hF, 32'h0);
        idle(2);
        repeat (5) @(posedge clk);
        #1;
        do_cmd(2, 1'b0, 1'b1, 32'h20, 4'hF, 32'h33330000);
        do_cmd(2, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        do_cmd(2, 1'b0, 1'b1, 32'h24, 4'hF, 32'h44440000);
        do_cmd(2, 1'b1, 1'b0, 32'h24, 4'hF, 32'h0);
        idle(2);
        pulse_reset(2);
        repeat (4) @(posedge clk);
        #1;
        do_cmd(2, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        do_cmd(2, 1'b1, 1'b0, 32'h24, 4'hF, 32'h0);
        idle(2);
        repeat (4) @(posedge clk);
        #1;

        // Randomised traffic on every instance
        for (int i = 0; i < NI; i++) begin
            for (int n = 0; n < 120; n++) begin
                kind = $urandom_range(0, 99);
                ra   = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
                rr   = 1'($urandom_range(0, 1));
                if (kind < 40) begin
                    do_cmd(i, 1'b1, 1'b0, ra, 4'($urandom_range(0, 15)), $urandom);
                end else if (kind < 75) begin
                    do_cmd(i, 1'b0, 1'b1, ra, 4'($urandom_range(0, 15)), $urandom);
                end else if (kind < 85) begin
                    ra = ((n % 2) == 0) ? (32'h00001000 | ra) : (32'h80000000 | ra);
                    do_cmd(i, rr, ~rr, ra, 4'hF, $urandom);
                end else if (kind < 92) begin
                    do_cmd(i, 1'b1, 1'b1, ra, 4'hF, $urandom);
                end else begin
                    idle(i);
                    @(posedge clk); #1;
                end
                if ($urandom_range(0, 3) == 0) begin
                    idle(i);
                    @(posedge clk); #1;
                end
            end
            idle(i);
            repeat (5) @(posedge clk);
            #1;
        end

        repeat (10) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++)
            chk($sformatf("drained_i%0d", i), 64'(expq[i].size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
